fir_tap_arb: RTL and testbench
==============================

Name: fir_tap_arb

Overview:
- Arbitrates the single-port tap-coefficient BRAM between two requesters:
  - the AXI-lite configuration side (host tap reads/writes);
  - the FIR compute engine (coefficient fetch per MAC step).
- Sits between the register/AXI-lite block, the FIR datapath sequencer and the tap RAM pins.
- Guarantees one BRAM access per cycle, deterministic read-return routing and bounded host wait while the engine streams.

Parameters:
- pADDR_WIDTH, 12, tap RAM byte-address width.
- pDATA_WIDTH, 32, tap word width.
- pMAX_WAIT, 8, maximum consecutive cycles host may be denied while engine is busy (range 1..255).

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  asynchronous active-low reset.
- eng_busy  in  1  engine running (ap_idle low); selects arbitration mode.
- cfg_req  in  1  host access request; held with addr/we/wdata until cfg_gnt.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  pADDR_WIDTH  byte address, word aligned.
- cfg_wdata  in  pDATA_WIDTH  write data.
- cfg_gnt  out  1  access performed this cycle.
- cfg_rvalid  out  1  read data valid (one cycle after read grant).
- cfg_rdata  out  pDATA_WIDTH  read data.
- cfg_err  out  1  write rejected (see Optional Feature); 0 when macro absent.
- eng_req  in  1  engine read request; held until eng_gnt.
- eng_addr  in  pADDR_WIDTH  byte address.
- eng_gnt  out  1  access performed this cycle.
- eng_rvalid  out  1  coefficient valid (one cycle after grant).
- eng_rdata  out  pDATA_WIDTH  coefficient.
- tap_WE  out  4  BRAM byte write enables.
- tap_EN  out  1  BRAM enable.
- tap_Di  out  pDATA_WIDTH  BRAM write data.
- tap_A  out  pADDR_WIDTH  BRAM address.
- tap_Do  in  pDATA_WIDTH  BRAM read data, valid one cycle after an EN read.

Behaviour:
- Grant is combinational in the request cycle. BRAM pins are driven combinationally from the winner:
  - tap_EN = 1.
  - tap_A = winner address.
  - tap_WE = 4'hF for a granted cfg write, else 0.
  - tap_Di = cfg_wdata on a cfg write, else 0.
- With no grant, tap_EN, tap_WE, tap_A and tap_Di are all 0.
- Only one of cfg_gnt / eng_gnt is ever high in a cycle.
- Mode IDLE (eng_busy = 0): round-robin.
  - last_winner register, reset value = eng.
  - If both request, the requester that is not last_winner wins; a single requester always wins.
  - last_winner updates on every grant.
- Mode BUSY (eng_busy = 1): engine priority with starvation guard.
  - 8-bit wait_cnt increments each cycle cfg_req = 1 and cfg is not granted.
  - When wait_cnt == pMAX_WAIT, cfg wins over eng that cycle.
  - wait_cnt clears on cfg grant or when cfg_req = 0.
  - wait_cnt also clears on the eng_busy falling edge.
- Read return:
  - Registered 1-bit owner tag plus a valid flag, set on any read grant.
  - Next cycle: the owner's rvalid = 1 and its rdata = tap_Do. The other side's rdata = 0.
  - Write grants produce no rvalid.
- Back-to-back grants to alternating owners are legal; each rvalid follows its own grant by exactly one cycle.
- A requester dropping req without a grant is legal; no state besides wait_cnt is affected.
- Reset (asynchronous, any time, including mid-read):
  - Outputs go to 0; wait_cnt = 0; last_winner = eng; pending rvalid discarded.
  - No rvalid is issued after reset release for a pre-reset grant.
- eng_busy toggling in the same cycle as a conflict: mode is sampled combinationally that cycle.

Optional Feature:
- Macro: FIR_TAP_ARB_WRITE_LOCK_EN.
- Defined:
  - While eng_busy = 1, a cfg write is acknowledged without touching BRAM: cfg_gnt = 1, tap_EN = 0 for that request, cfg_err = 1 for exactly that cycle.
  - cfg reads are unaffected.
  - wait_cnt clears as on a normal grant.
- Undefined: cfg writes during busy are arbitrated like reads; cfg_err is tied 0.

Test Plan:
- Idle, cfg write addr 0x08 data 0x0000_0005, then cfg read 0x08 -> gnt same cycle, tap_WE = F, tap_A = 0x08; read cfg_rvalid one cycle later with cfg_rdata = 5, eng_rvalid = 0.
- Idle, both request every cycle for 6 cycles -> grants alternate, cfg first (last_winner = eng after reset): cfg, eng, cfg, eng, cfg, eng.
- eng_busy = 1, eng_req continuous, cfg_req read held, pMAX_WAIT = 8 -> cfg granted on the 9th cycle of requesting, eng stalled that cycle only, eng resumes next cycle.
- Grant cfg read at cycle N, eng read at N+1 -> cfg_rvalid at N+1, eng_rvalid at N+2, each carrying its own tap_Do, never both high together.
- Assert axis_rst_n low in the cycle after an eng read grant -> eng_rvalid never pulses, all outputs 0; after release, idle conflict goes to cfg.
- With FIR_TAP_ARB_WRITE_LOCK_EN, eng_busy = 1, cfg write 0x10 -> cfg_gnt = 1 and cfg_err = 1 for one cycle, tap_WE = 0; a subsequent idle read of 0x10 returns the old value.

Source files
------------

// File: rtl/fir_tap_arb_if.sv
// Bundle of host-config, engine-fetch and tap-RAM pin signals around fir_tap_arb.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fir_tap_arb_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   eng_busy;
  logic                   cfg_req;
  logic                   cfg_we;
  logic [pADDR_WIDTH-1:0] cfg_addr;
  logic [pDATA_WIDTH-1:0] cfg_wdata;
  logic                   cfg_gnt;
  logic                   cfg_rvalid;
  logic [pDATA_WIDTH-1:0] cfg_rdata;
  logic                   cfg_err;
  logic                   eng_req;
  logic [pADDR_WIDTH-1:0] eng_addr;
  logic                   eng_gnt;
  logic                   eng_rvalid;
  logic [pDATA_WIDTH-1:0] eng_rdata;
  logic [3:0]             tap_WE;
  logic                   tap_EN;
  logic [pDATA_WIDTH-1:0] tap_Di;
  logic [pADDR_WIDTH-1:0] tap_A;
  logic [pDATA_WIDTH-1:0] tap_Do;

  modport master (
    output eng_busy, cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr, tap_Do,
    input  cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, eng_gnt, eng_rvalid, eng_rdata,
    input  tap_WE, tap_EN, tap_Di, tap_A
  );

  modport slave (
    input  eng_busy, cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr, tap_Do,
    output cfg_gnt, cfg_rvalid, cfg_rdata, cfg_err, eng_gnt, eng_rvalid, eng_rdata,
    output tap_WE, tap_EN, tap_Di, tap_A
  );
endinterface

// File: rtl/fir_tap_arb.sv
// Single-port tap BRAM arbiter: round-robin when idle, engine priority with a starvation
// guard when busy. Optional FIR_TAP_ARB_WRITE_LOCK_EN acks-and-drops host writes while busy.
module fir_tap_arb #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pMAX_WAIT   = 8
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  fir_tap_arb_if.slave      bus
);

  typedef enum logic {OwnEng = 1'b0, OwnCfg = 1'b1} owner_e;

  localparam logic [7:0] MaxWait = 8'(pMAX_WAIT);

  owner_e     last_winner_q, last_winner_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       busy_q;
  logic       cfg_win, eng_win, lock;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      last_winner_q <= OwnEng;
      rd_owner_q    <= OwnEng;
      rd_valid_q    <= 1'b0;
      wait_cnt_q    <= 8'd0;
      busy_q        <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      rd_owner_q    <= rd_owner_d;
      rd_valid_q    <= rd_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      busy_q        <= bus.eng_busy;
    end
  end

  always_comb begin
    cfg_win = 1'b0;
    eng_win = 1'b0;
    lock    = 1'b0;
    // Grants are masked during reset so every output reads 0 while axis_rst_n is low.
    if (axis_rst_n) begin
      if (bus.eng_busy) begin
        if (bus.cfg_req && (!bus.eng_req || wait_cnt_q == MaxWait)) cfg_win = 1'b1;
        else if (bus.eng_req)                                         eng_win = 1'b1;
      end else begin
        if (bus.cfg_req && (!bus.eng_req || last_winner_q == OwnEng)) cfg_win = 1'b1;
        else if (bus.eng_req)                                           eng_win = 1'b1;
      end
    end
`ifdef FIR_TAP_ARB_WRITE_LOCK_EN
    lock = cfg_win && bus.cfg_we && bus.eng_busy;
`endif

    bus.cfg_gnt = cfg_win;
    bus.eng_gnt = eng_win;
    bus.cfg_err = lock;
    bus.tap_EN  = 1'b0;
    bus.tap_WE  = 4'h0;
    bus.tap_A   = '0;
    bus.tap_Di  = '0;
    if (cfg_win && !lock) begin
      bus.tap_EN = 1'b1;
      bus.tap_A  = bus.cfg_addr;
      if (bus.cfg_we) begin
        bus.tap_WE = 4'hF;
        bus.tap_Di = bus.cfg_wdata;
      end
    end else if (eng_win) begin
      bus.tap_EN = 1'b1;
      bus.tap_A  = bus.eng_addr;
    end

    rd_valid_d    = (cfg_win && !bus.cfg_we) || eng_win;
    rd_owner_d    = cfg_win ? OwnCfg : OwnEng;
    last_winner_d = cfg_win ? OwnCfg : (eng_win ? OwnEng : last_winner_q);

    wait_cnt_d = wait_cnt_q;
    if (!bus.cfg_req || cfg_win || (busy_q && !bus.eng_busy)) wait_cnt_d = 8'd0;
    else if (wait_cnt_q != 8'hFF)                            wait_cnt_d = wait_cnt_q + 8'd1;

    bus.cfg_rvalid = rd_valid_q && (rd_owner_q == OwnCfg);
    bus.eng_rvalid = rd_valid_q && (rd_owner_q == OwnEng);
    bus.cfg_rdata  = bus.cfg_rvalid ? bus.tap_Do : '0;
    bus.eng_rdata  = bus.eng_rvalid ? bus.tap_Do : '0;
  end

endmodule

// File: tb/tb_fir_tap_arb.sv
// Directed bench for fir_tap_arb with a read-first BRAM model on the tap pins.
module tb_fir_tap_arb;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  fir_tap_arb_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_tap_arb #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pMAX_WAIT(8)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
      bus.tap_Do <= 32'h0;
    end else if (bus.tap_EN) begin
      if (bus.tap_WE == 4'hF) mem[bus.tap_A[5:2]] <= bus.tap_Di;
      bus.tap_Do <= mem[bus.tap_A[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.eng_busy  = 1'b0;
    bus.cfg_req   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.eng_req   = 1'b0;
    bus.eng_addr  = '0;
  endtask

  initial begin
    logic prev_cfg;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_gnt", {31'b0, bus.cfg_gnt}, 32'd0);
    chk("rst_eng_gnt", {31'b0, bus.eng_gnt}, 32'd0);
    chk("rst_tap_en", {31'b0, bus.tap_EN}, 32'd0);
    chk("rst_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd0);
    chk("rst_cfg_err", {31'b0, bus.cfg_err}, 32'd0);
    rst_n = 1'b1;

    // Host write 5 to 0x08, then read it back.
    tick();
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 12'h008; bus.cfg_wdata = 32'h5;
    #1;
    chk("wr_gnt", {31'b0, bus.cfg_gnt}, 32'd1);
    chk("wr_we", {28'b0, bus.tap_WE}, 32'hF);
    chk("wr_addr", {20'b0, bus.tap_A}, 32'h8);
    chk("wr_di", bus.tap_Di, 32'h5);
    chk("wr_en", {31'b0, bus.tap_EN}, 32'd1);
    tick();
    bus.cfg_we = 1'b0;
    #1;
    chk("rd_gnt", {31'b0, bus.cfg_gnt}, 32'd1);
    chk("rd_we", {28'b0, bus.tap_WE}, 32'h0);
    chk("rd_di", bus.tap_Di, 32'h0);
    chk("wr_no_rvalid", {31'b0, bus.cfg_rvalid}, 32'd0);
    tick();
    bus.cfg_req = 1'b0;
    #1;
    chk("rd_rvalid", {31'b0, bus.cfg_rvalid}, 32'd1);
    chk("rd_rdata", bus.cfg_rdata, 32'h5);
    chk("rd_eng_rvalid", {31'b0, bus.eng_rvalid}, 32'd0);
    chk("rd_eng_rdata", bus.eng_rdata, 32'h0);
    chk("nogrant_en", {31'b0, bus.tap_EN}, 32'd0);
    chk("nogrant_addr", {20'b0, bus.tap_A}, 32'h0);

    // Fresh reset so the first idle conflict goes to cfg.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prev_cfg = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 12'h004;
      bus.eng_req = 1'b1; bus.eng_addr = 12'h00C;
      #1;
      chk($sformatf("rr_cfg_gnt_%0d", i), {31'b0, bus.cfg_gnt}, {31'b0, (i % 2) == 0});
      chk($sformatf("rr_eng_gnt_%0d", i), {31'b0, bus.eng_gnt}, {31'b0, (i % 2) == 1});
      if (i > 0) begin
        chk($sformatf("rr_rvalid_%0d", i), {30'b0, bus.cfg_rvalid, bus.eng_rvalid},
            prev_cfg ? 32'd2 : 32'd1);
        chk($sformatf("rr_rdata_%0d", i), bus.cfg_rdata | bus.eng_rdata,
            prev_cfg ? 32'h101 : 32'h103);
      end
      prev_cfg = ((i % 2) == 0);
    end
    tick();
    bus.cfg_req = 1'b0; bus.eng_req = 1'b0;
    #1;
    chk("rr_last_eng_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd1);
    chk("rr_last_eng_rdata", bus.eng_rdata, 32'h103);

    // Busy: engine streams, host read held; guard grants host on the 9th cycle.
    for (int i = 1; i <= 9; i++) begin
      tick();
      bus.eng_busy = 1'b1; bus.eng_req = 1'b1; bus.eng_addr = 12'h00C;
      bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 12'h004;
      #1;
      chk($sformatf("busy_cfg_gnt_%0d", i), {31'b0, bus.cfg_gnt}, {31'b0, i == 9});
      chk($sformatf("busy_eng_gnt_%0d", i), {31'b0, bus.eng_gnt}, {31'b0, i != 9});
    end
    tick();
    bus.cfg_req = 1'b0;
    #1;
    chk("busy_eng_resume", {31'b0, bus.eng_gnt}, 32'd1);
    chk("busy_cfg_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd2);
    chk("busy_cfg_rdata", bus.cfg_rdata, 32'h101);
    tick();
    bus.eng_req = 1'b0; bus.eng_busy = 1'b0;
    #1;
    chk("busy_eng_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd1);
    chk("busy_eng_rdata", bus.eng_rdata, 32'h103);

    // Reset right after an engine read grant discards the pending return.
    tick();
    bus.eng_req = 1'b1; bus.eng_addr = 12'h008;
    #1;
    chk("mid_eng_gnt", {31'b0, bus.eng_gnt}, 32'd1);
    tick();
    bus.eng_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd0);
    chk("mid_rst_rdata", bus.eng_rdata, 32'h0);
    chk("mid_rst_en", {31'b0, bus.tap_EN}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rvalid", {30'b0, bus.cfg_rvalid, bus.eng_rvalid}, 32'd0);
    tick();
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 12'h004;
    bus.eng_req = 1'b1; bus.eng_addr = 12'h00C;
    #1;
    chk("post_rst_conflict", {30'b0, bus.cfg_gnt, bus.eng_gnt}, 32'd2);
    tick();
    bus.cfg_req = 1'b0; bus.eng_req = 1'b0;
    #1;
    chk("post_rst_rdata", bus.cfg_rdata, 32'h101);

    // Host write while busy, then idle read of the same word.
    tick();
    bus.eng_busy = 1'b1;
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 12'h010; bus.cfg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("lock_gnt", {31'b0, bus.cfg_gnt}, 32'd1);
`ifdef FIR_TAP_ARB_WRITE_LOCK_EN
    chk("lock_err", {31'b0, bus.cfg_err}, 32'd1);
    chk("lock_we", {28'b0, bus.tap_WE}, 32'h0);
    chk("lock_en", {31'b0, bus.tap_EN}, 32'd0);
`else
    chk("lock_err", {31'b0, bus.cfg_err}, 32'd0);
    chk("lock_we", {28'b0, bus.tap_WE}, 32'hF);
    chk("lock_en", {31'b0, bus.tap_EN}, 32'd1);
`endif
    tick();
    bus.eng_busy = 1'b0; bus.cfg_we = 1'b0;
    #1;
    chk("lock_rd_gnt", {31'b0, bus.cfg_gnt}, 32'd1);
    chk("lock_rd_err", {31'b0, bus.cfg_err}, 32'd0);
    chk("lock_wr_no_rvalid", {31'b0, bus.cfg_rvalid}, 32'd0);
    tick();
    bus.cfg_req = 1'b0;
    #1;
`ifdef FIR_TAP_ARB_WRITE_LOCK_EN
    chk("lock_rd_data", bus.cfg_rdata, 32'h104);
`else
    chk("lock_rd_data", bus.cfg_rdata, 32'hDEAD_BEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Mutual exclusion of grants is checked every cycle.
  always @(negedge clk) begin
    if (rst_n) chk("one_gnt", {31'b0, bus.cfg_gnt & bus.eng_gnt}, 32'd0);
  end
endmodule
